// File: rtl/cbx_param_pkg.sv
// Shared constants, FSM state type and elaboration helpers for the parametrised
// connection block (cbx_param_cfg).
package cbx_param_pkg;

   localparam int CBX_DEF_CHAN_W   = 20;
   localparam int CBX_DEF_NUM_IPIN = 9;
   localparam int CBX_DEF_MUX_SIZE = 10;
   localparam int CBX_DEF_STRIDE   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_EVAL  = 2'd2
   } cfg_state_e;

   // Select width for an n-input mux; a 1-input mux still gets one select bit.
   function automatic int sel_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   // Track feeding mux input pair p of IPIN k.
   function automatic int track_idx(input int k, input int p, input int stride,
                                    input int chan_w);
      return (k + p * stride) % chan_w;
   endfunction

endpackage

// File: rtl/cbx_ipin_mux.sv
// Combinational IPIN select mux; any select value at or beyond MUX_SIZE drives 0.
module cbx_ipin_mux
   import cbx_param_pkg::*;
#(
   parameter int MUX_SIZE = CBX_DEF_MUX_SIZE,
   parameter int SEL_W    = 4
) (
   input  logic [MUX_SIZE-1:0] in,
   input  logic [SEL_W-1:0]    sel,
   output logic                out
);

   always_comb begin
      out = 1'b0;
      for (int j = 0; j < MUX_SIZE; j++) begin
         if (sel == SEL_W'(j)) out = in[j];
      end
   end

endmodule

// File: rtl/cbx_param_cfg.sv
// Parametrised horizontal connection block with double-buffered config chain.
// Optional readback of the active configuration: define CBX_READBACK_EN.
module cbx_param_cfg
   import cbx_param_pkg::*;
#(
   parameter int CHAN_W   = CBX_DEF_CHAN_W,
   parameter int NUM_IPIN = CBX_DEF_NUM_IPIN,
   parameter int MUX_SIZE = CBX_DEF_MUX_SIZE,
   parameter int STRIDE   = CBX_DEF_STRIDE
) (
   input  logic                prog_clk,
   input  logic                pReset,
   input  logic                config_enable,
   input  logic                ccff_head,
   output logic                ccff_tail,
   input  logic [CHAN_W-1:0]   chanx_left_in,
   input  logic [CHAN_W-1:0]   chanx_right_in,
   output logic [CHAN_W-1:0]   chanx_left_out,
   output logic [CHAN_W-1:0]   chanx_right_out,
   output logic [NUM_IPIN-1:0] ipin_out,
   output logic                cfg_done,
   output logic                cfg_err
`ifdef CBX_READBACK_EN
   ,
   input  logic                readback_req
`endif
);

   localparam int SEL_W    = sel_width(MUX_SIZE);
   localparam int CFG_BITS = NUM_IPIN * SEL_W;
   localparam int CNT_W    = $clog2(CFG_BITS + 2);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

   cfg_state_e           r_state;
   cfg_state_e           w_state_nxt;
   logic                 r_cfg_en_q;
   logic [CFG_BITS-1:0]  r_chain;
   logic [CFG_BITS-1:0]  r_active;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_base;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic                 r_cfg_done;
   logic                 r_cfg_err;
   logic                 w_eval;
   logic                 w_commit;
   logic                 w_reject;
   logic                 w_rb_load;

   assign chanx_left_out  = chanx_right_in;
   assign chanx_right_out = chanx_left_in;
   assign ccff_tail       = r_chain[CFG_BITS-1];
   assign cfg_done        = r_cfg_done;
   assign cfg_err         = r_cfg_err;

   assign w_eval   = (r_state == ST_EVAL);
   assign w_commit = w_eval && (r_cnt == CNT_FULL);
   assign w_reject = w_eval && (r_cnt != CNT_FULL);

`ifdef CBX_READBACK_EN
   assign w_rb_load = readback_req & ~config_enable;
`else
   assign w_rb_load = 1'b0;
`endif

   // Commit FSM: SHIFT tracks a burst, EVAL is the single cycle that decides
   // commit or reject once the registered enable shows the burst has ended.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:  if (config_enable) w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (r_cfg_en_q && !config_enable) w_state_nxt = ST_EVAL;
         ST_EVAL:  w_state_nxt = config_enable ? ST_SHIFT : ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Clearing happens before the increment so a shift in the EVAL cycle
   // starts the next frame at a count of one.
   always_comb begin
      w_cnt_base = r_cnt;
      if (w_eval || w_rb_load) w_cnt_base = '0;
      w_cnt_nxt = w_cnt_base;
      if (config_enable && (w_cnt_base != CNT_SAT)) w_cnt_nxt = w_cnt_base + CNT_W'(1);
   end

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         r_state    <= ST_IDLE;
         r_cfg_en_q <= 1'b0;
         r_chain    <= '0;
         r_active   <= '0;
         r_cnt      <= '0;
         r_cfg_done <= 1'b0;
         r_cfg_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cfg_en_q <= config_enable;
         r_cnt      <= w_cnt_nxt;
         r_cfg_done <= w_commit;
         r_cfg_err  <= w_reject;
         if (w_commit) r_active <= r_chain;
         if (config_enable) begin
            r_chain <= {r_chain[CFG_BITS-2:0], ccff_head};
         end
`ifdef CBX_READBACK_EN
         else if (readback_req) begin
            r_chain <= r_active;
         end
`endif
      end
   end

   // Input j of IPIN k: pair j/2 picks the track, parity picks left or right.
   for (genvar k = 0; k < NUM_IPIN; k++) begin : g_ipin
      logic [MUX_SIZE-1:0] w_mux_in;
      for (genvar j = 0; j < MUX_SIZE; j++) begin : g_in
         localparam int TRK = track_idx(k, j / 2, STRIDE, CHAN_W);
         if ((j % 2) == 0) begin : g_left
            assign w_mux_in[j] = chanx_left_in[TRK];
         end else begin : g_right
            assign w_mux_in[j] = chanx_right_in[TRK];
         end
      end

      cbx_ipin_mux #(
         .MUX_SIZE (MUX_SIZE),
         .SEL_W    (SEL_W)
      ) u_mux (
         .in  (w_mux_in),
         .sel (r_active[k*SEL_W +: SEL_W]),
         .out (ipin_out[k])
      );
   end

endmodule

// File: tb/tb_cbx_param_cfg.sv
// Randomised self-checking bench for cbx_param_cfg against a frame-level model.
module tb_cbx_param_cfg;

   localparam int CHAN_W   = 20;
   localparam int NUM_IPIN = 9;
   localparam int MUX_SIZE = 10;
   localparam int STRIDE   = 3;
   localparam int SEL_W    = 4;
   localparam int CFG_BITS = 36;
`ifdef CBX_READBACK_EN
   localparam bit RB_EN = 1'b1;
`else
   localparam bit RB_EN = 1'b0;
`endif

   logic                prog_clk = 1'b0;
   logic                pReset = 1'b1;
   logic                config_enable = 1'b0;
   logic                ccff_head = 1'b0;
   logic                ccff_tail;
   logic [CHAN_W-1:0]   chanx_left_in = '0;
   logic [CHAN_W-1:0]   chanx_right_in = '0;
   logic [CHAN_W-1:0]   chanx_left_out;
   logic [CHAN_W-1:0]   chanx_right_out;
   logic [NUM_IPIN-1:0] ipin_out;
   logic                cfg_done;
   logic                cfg_err;
`ifdef CBX_READBACK_EN
   logic                readback_req = 1'b0;
`endif

   cbx_param_cfg #(
      .CHAN_W   (CHAN_W),
      .NUM_IPIN (NUM_IPIN),
      .MUX_SIZE (MUX_SIZE),
      .STRIDE   (STRIDE)
   ) dut (
      .prog_clk        (prog_clk),
      .pReset          (pReset),
      .config_enable   (config_enable),
      .ccff_head       (ccff_head),
      .ccff_tail       (ccff_tail),
      .chanx_left_in   (chanx_left_in),
      .chanx_right_in  (chanx_right_in),
      .chanx_left_out  (chanx_left_out),
      .chanx_right_out (chanx_right_out),
      .ipin_out        (ipin_out),
      .cfg_done        (cfg_done),
      .cfg_err         (cfg_err)
`ifdef CBX_READBACK_EN
      ,
      .readback_req    (readback_req)
`endif
   );

   always #5 prog_clk = ~prog_clk;

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   // Frame-level model: history of shifted bits, active word, burst length.
   logic                m_hist[$];
   logic [CFG_BITS-1:0] m_act = '0;
   int                  m_burst = 0;
   bit                  m_eval_pend = 1'b0;
   bit                  m_prev_en = 1'b0;
   logic                m_done = 1'b0;
   logic                m_err = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [CFG_BITS-1:0] model_chain();
      logic [CFG_BITS-1:0] c;
      int n;
      c = '0;
      n = m_hist.size();
      for (int i = 0; i < CFG_BITS; i++) begin
         if (i < n) c[i] = m_hist[n-1-i];
      end
      return c;
   endfunction

   function automatic logic [NUM_IPIN-1:0] exp_ipin(input logic [CFG_BITS-1:0] act,
                                                    input logic [CHAN_W-1:0] l,
                                                    input logic [CHAN_W-1:0] r);
      logic [NUM_IPIN-1:0] v;
      int s, t;
      for (int k = 0; k < NUM_IPIN; k++) begin
         s = int'(act[k*SEL_W +: SEL_W]);
         if (s >= MUX_SIZE) v[k] = 1'b0;
         else begin
            t = (k + (s / 2) * STRIDE) % CHAN_W;
            v[k] = ((s % 2) == 0) ? l[t] : r[t];
         end
      end
      return v;
   endfunction

   task automatic model_edge(input logic rst, input logic en, input logic hd, input logic rb);
      logic [CFG_BITS-1:0] chain_now;
      logic [CFG_BITS-1:0] act_old;
      chain_now = model_chain();
      act_old   = m_act;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (rst) begin
         m_hist.delete();
         m_act = '0;
         m_burst = 0;
         m_eval_pend = 1'b0;
         m_prev_en = 1'b0;
      end else begin
         if (m_eval_pend) begin
            if (m_burst == CFG_BITS) begin
               m_act  = chain_now;
               m_done = 1'b1;
            end else m_err = 1'b1;
            m_burst = 0;
            m_eval_pend = 1'b0;
         end
         if (en) begin
            m_hist.push_back(hd);
            if (m_hist.size() > CFG_BITS) void'(m_hist.pop_front());
            m_burst++;
         end else if (RB_EN && rb) begin
            m_hist.delete();
            for (int i = CFG_BITS - 1; i >= 0; i--) m_hist.push_back(act_old[i]);
            m_burst = 0;
         end
         if (m_prev_en && !en) m_eval_pend = 1'b1;
         m_prev_en = en;
      end
   endtask

   task automatic cycle(input logic rst, input logic en, input logic hd, input logic rb);
      pReset        = rst;
      config_enable = en;
      ccff_head     = hd;
`ifdef CBX_READBACK_EN
      readback_req  = rb;
`endif
      chanx_left_in  = CHAN_W'($urandom);
      chanx_right_in = CHAN_W'($urandom);
      @(posedge prog_clk);
      model_edge(rst, en, hd, rb);
      #1;
   endtask

   task automatic shift_word(input logic [CFG_BITS-1:0] w, input int n);
      int idx;
      logic hd;
      for (int i = 0; i < n; i++) begin
         idx = CFG_BITS - 1 - i;
         hd = (idx >= 0) ? w[idx] : 1'($urandom);
         cycle(1'b0, 1'b1, hd, 1'b0);
      end
   endtask

   always @(negedge prog_clk) begin
      if (checking) begin
         check("tail", 64'(ccff_tail), 64'(model_chain() >> (CFG_BITS - 1)));
         check("ipin", 64'(ipin_out), 64'(exp_ipin(m_act, chanx_left_in, chanx_right_in)));
         check("done", 64'(cfg_done), 64'(m_done));
         check("err", 64'(cfg_err), 64'(m_err));
         check("left_out", 64'(chanx_left_out), 64'(chanx_right_in));
         check("right_out", 64'(chanx_right_out), 64'(chanx_left_in));
      end
   end

   initial begin
      logic [CFG_BITS-1:0] f;
      logic [CFG_BITS-1:0] p;
      int len, gap, rpos;

      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      checking = 1'b1;
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("rst_tail", 64'(ccff_tail), 64'd0);
      check("rst_done", 64'({cfg_done, cfg_err}), 64'd0);
      for (int k = 0; k < NUM_IPIN; k++)
         check("rst_ipin", 64'(ipin_out[k]), 64'(chanx_left_in[k]));

      // Full frame, field k = k.
      f = '0;
      for (int k = 0; k < NUM_IPIN; k++) f[k*SEL_W +: SEL_W] = SEL_W'(k);
      shift_word(f, CFG_BITS);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("full_early", 64'(cfg_done), 64'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("full_done", 64'({cfg_done, cfg_err}), 64'b10);
      check("full_ipin4", 64'(ipin_out[4]), 64'(chanx_left_in[10]));
      check("full_ipin1", 64'(ipin_out[1]), 64'(chanx_right_in[1]));
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("full_pulse_w", 64'(cfg_done), 64'd0);

      // Short frame keeps the previous configuration.
      shift_word(CFG_BITS'({$urandom, $urandom}), 35);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("short_err", 64'({cfg_done, cfg_err}), 64'b01);
      check("short_ipin0", 64'(ipin_out[0]), 64'(chanx_left_in[0]));
      check("short_ipin4", 64'(ipin_out[4]), 64'(chanx_left_in[10]));

      // Overlong frame.
      shift_word(CFG_BITS'({$urandom, $urandom}), 40);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("long_err", 64'({cfg_done, cfg_err}), 64'b01);

      // Chain delay: single 1 reaches the tail after exactly 36 shifts.
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 2; i <= CFG_BITS; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0);
         if (i == CFG_BITS - 1) check("delay_35", 64'(ccff_tail), 64'd0);
         if (i == CFG_BITS)     check("delay_36", 64'(ccff_tail), 64'd1);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("delay_done", 64'(cfg_done), 64'd1);

      // Out-of-range select on IPIN 2, select 3 on IPIN 0.
      f = CFG_BITS'({$urandom, $urandom});
      f[2*SEL_W +: SEL_W] = 4'd15;
      f[0 +: SEL_W] = 4'd3;
      shift_word(f, CFG_BITS);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0);
         check("oor_ipin2", 64'(ipin_out[2]), 64'd0);
         check("sel3_ipin0", 64'(ipin_out[0]), 64'(chanx_right_in[3]));
      end

      // Reset in the middle of a burst.
      shift_word(CFG_BITS'({$urandom, $urandom}), 20);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("rstmid_quiet", 64'({cfg_done, cfg_err}), 64'd0);
      f = CFG_BITS'({$urandom, $urandom});
      shift_word(f, CFG_BITS);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("rstmid_done", 64'({cfg_done, cfg_err}), 64'b10);

`ifdef CBX_READBACK_EN
      p = CFG_BITS'({$urandom, $urandom});
      shift_word(p, CFG_BITS);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check("rb_quiet", 64'({cfg_done, cfg_err}), 64'd0);
      check("rb_bit35", 64'(ccff_tail), 64'(p[CFG_BITS-1]));
      for (int i = 1; i < CFG_BITS; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0);
         check("rb_bit", 64'(ccff_tail), 64'(p[CFG_BITS-1-i]));
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("rb_next_done", 64'(cfg_done), 64'd1);
`else
      p = '0;
`endif

      // Random bursts, gaps, lengths, readbacks and mid-burst resets.
      for (int it = 0; it < 80; it++) begin
         len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 45)) : CFG_BITS;
         gap  = int'($urandom_range(1, 3));
         rpos = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         f = CFG_BITS'({$urandom, $urandom});
         for (int i = 0; i < len; i++) begin
            if (i == rpos) cycle(1'b1, 1'($urandom), 1'($urandom), 1'b0);
            else cycle(1'b0, 1'b1, (CFG_BITS - 1 - i >= 0) ? f[CFG_BITS-1-i] : 1'($urandom), 1'b0);
         end
         for (int g = 0; g < gap; g++)
            cycle(1'b0, 1'b0, 1'($urandom), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
